alu_div_16bit: RTL and testbench

//  Multi-cycle 16-bit iterative restoring divider for the ALU; the inverse

---
 rtl/alu_pkg.sv | 11 +
 rtl/CLA_16bit.sv | 41 ++++
 rtl/alu_div_16bit.sv | 213 +++++++++++++++++++++
 tb/tb_alu_div_16bit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and divider constants.
package alu_pkg;

  localparam int unsigned DIV_ITERS  = 16;
  localparam logic [15:0] DIV_ZERO_Q = 16'hFFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/CLA_16bit.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;

  assign g = a & b;
  assign p = a ^ b;

  // Ripple inside each nibble, group generate/propagate between nibbles
  always_comb begin
    c    = '0;
    gg   = '0;
    gp   = '0;
    c[0] = cin;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];

endmodule

// File: rtl/alu_div_16bit.sv
// Multi-cycle 16-bit restoring divider, one quotient bit per cycle.
// Optional feature macro: DIV_SIGNED_EN (two's-complement, truncate toward 0).
module alu_div_16bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // The trial subtractor is a fixed 16-bit CLA, so no other width is usable
  if (WIDTH != 16) begin : g_bad_width
    $error("alu_div_16bit: WIDTH must be 16");
  end

  logic [1:0]       state_q,     state_d;
  logic [15:0]      rem_q,       rem_d;
  logic [15:0]      q_q,         q_d;
  logic [15:0]      divisor_q,   divisor_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [15:0]      quotient_q,  quotient_d;
  logic [15:0]      remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  logic        shift_c;
  logic [15:0] rem_sh;
  logic [15:0] q_sh;
  logic [15:0] cla_b;
  logic        cla_cin;
  logic [15:0] trial;
  logic        trial_cout;
  logic        accept;
  logic [15:0] rem_nx;
  logic [15:0] q_nx;
  logic [15:0] dividend_mag;
  logic [15:0] q_fix;
  logic [15:0] r_fix;

  // Shift {rem,q} left by one; the bit falling out of rem is the 17th bit
  assign shift_c = rem_q[15];
  assign rem_sh  = {rem_q[14:0], q_q[15]};
  assign q_sh    = {q_q[14:0], 1'b0};

  CLA_16bit u_trial (
    .a    (rem_sh),
    .b    (cla_b),
    .cin  (cla_cin),
    .sum  (trial),
    .cout (trial_cout)
  );

  assign accept = trial_cout | shift_c;
  assign rem_nx = accept ? trial : rem_sh;
  assign q_nx   = {q_sh[15:1], accept};

`ifdef DIV_SIGNED_EN
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dneg_q, dneg_d;
  logic [15:0] nega_in;
  logic [15:0] nega_out;
  logic [15:0] negb_out;
  logic        nega_cout;
  logic        negb_cout;

  // Negator A serves the dividend magnitude at load and the quotient at finish
  assign nega_in = (state_q == ST_RUN) ? q_nx : dividend;

  CLA_16bit u_neg_a (
    .a    (16'h0000),
    .b    (~nega_in),
    .cin  (1'b1),
    .sum  (nega_out),
    .cout (nega_cout)
  );

  CLA_16bit u_neg_b (
    .a    (16'h0000),
    .b    (~rem_nx),
    .cin  (1'b1),
    .sum  (negb_out),
    .cout (negb_cout)
  );

  // A negative divisor is added directly: rem + d == rem - |d| with same carry
  assign cla_b        = dneg_q ? divisor_q : ~divisor_q;
  assign cla_cin      = ~dneg_q;
  assign dividend_mag = dividend[15] ? nega_out : dividend;
  assign q_fix        = qneg_q ? nega_out : q_nx;
  assign r_fix        = rneg_q ? negb_out : rem_nx;
`else
  assign cla_b        = ~divisor_q;
  assign cla_cin      = 1'b1;
  assign dividend_mag = dividend;
  assign q_fix        = q_nx;
  assign r_fix        = rem_nx;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef DIV_SIGNED_EN
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dneg_d      = dneg_q;
`endif
    case (state_q)
      ST_RUN: begin
        rem_d  = rem_nx;
        q_d    = q_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = q_fix;
          remainder_d = r_fix;
          dbz_d       = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          if (divisor == 16'h0000) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            quotient_d  = DIV_ZERO_Q;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d   = ST_RUN;
            busy_d    = 1'b1;
            rem_d     = 16'h0000;
            q_d       = dividend_mag;
            divisor_d = divisor;
            cnt_d     = '0;
`ifdef DIV_SIGNED_EN
            qneg_d    = dividend[15] ^ divisor[15];
            rneg_d    = dividend[15];
            dneg_d    = divisor[15];
`endif
          end
        end
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DIV_SIGNED_EN
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dneg_q      <= dneg_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_16bit.sv
// Self-checking bench for alu_div_16bit against an arithmetic reference model.
module tb_alu_div_16bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;
  logic [15:0] prev_q;

  alu_div_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division from the operand values
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r, output logic z);
    if (b == 16'h0000) begin
      q = 16'hFFFF;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      z  = 1'b0;
    end
  endtask

  // One division; inj pulses start with junk operands at cycles 3 and 9
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input bit inj, input string tag);
    logic [15:0] eq;
    logic [15:0] er;
    logic        ez;
    int          cyc;
    int          bcnt;
    bit          seen;
    model(a, b, eq, er, ez);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    cyc  = 0;
    bcnt = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1 && b != 16'h0000) chk({tag, "_held"}, 32'(quotient), 32'(prev_q));
      if (busy) bcnt++;
      if (inj && (cyc == 3 || cyc == 9)) begin
        start    = 1'b1;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
      end
      if (done) seen = 1'b1;
    end
    chk({tag, "_lat"},  32'(cyc),  (b == 16'h0000) ? 32'd1 : 32'd17);
    chk({tag, "_busy"}, 32'(bcnt), (b == 16'h0000) ? 32'd0 : 32'd16);
    chk({tag, "_q"},    32'(quotient),    32'(eq));
    chk({tag, "_r"},    32'(remainder),   32'(er));
    chk({tag, "_dbz"},  32'(div_by_zero), 32'(ez));
    prev_q = eq;
  endtask

  initial begin
    int     dcnt;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] hold_q;
    checks   = 0;
    failures = 0;
    prev_q   = 16'h0000;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 16'h0000;
    divisor  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q",    32'(quotient), 32'd0);
    chk("rst_r",    32'(remainder), 32'd0);
    chk("rst_dbz",  32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run_div(16'd100, 16'd7, 1'b0, "d100_7");
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_q", 32'(quotient), 32'(prev_q));

    run_div(16'hFFFF, 16'd1, 1'b0, "ffff_1");
    run_div(16'h1234, 16'hFFFF, 1'b0, "x1234_ffff");
    run_div(16'd50, 16'd0, 1'b0, "d50_0");
    run_div(16'hBEEF, 16'd3, 1'b1, "inj");
    // Back-to-back: next start issued in the done cycle itself
    run_div(16'd1000, 16'd10, 1'b0, "b2b_a");
    run_div(16'd999, 16'd0, 1'b0, "b2b_zero");
    run_div(16'd77, 16'd9, 1'b0, "b2b_b");

    // Reset in the middle of a run aborts it with no done pulse
    repeat (2) @(posedge clk);
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_q",    32'(quotient), 32'd0);
    chk("mid_rst_r",    32'(remainder), 32'd0);
    chk("mid_rst_dbz",  32'(div_by_zero), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("mid_rst_nodone", 32'(dcnt), 32'd0);
    prev_q = 16'h0000;
    run_div(16'd9, 16'd3, 1'b0, "after_rst");

`ifdef DIV_SIGNED_EN
    run_div(16'hFFF9, 16'd2, 1'b0, "s_m7_2");
    run_div(16'd7, 16'hFFFE, 1'b0, "s_7_m2");
    run_div(16'h8000, 16'hFFFF, 1'b0, "s_min_m1");
`endif

    // Randomized operands, including zero and small divisors
    for (int n = 0; n < 24; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'($urandom);
        default: rb = ra >> $urandom_range(0, 15);
      endcase
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
      run_div(ra, rb, 1'b0, "rand");
    end

    hold_q = quotient;
    repeat (2) @(posedge clk);
    #1;
    chk("final_hold", 32'(quotient), 32'(hold_q));
    chk("final_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
